regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NRD, default 2, number of read ports (1..4).
REQ-003 Parameter TAGW, default 3, width of the reservation tag.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 rs_addr  input  NRD*5  packed read addresses; port k at bits [5k+4:5k].
REQ-007 rs_valid  output  NRD  per-port data-valid (not pending).
REQ-008 rs_data  output  NRD*XLEN  packed read data; port k at bits [XLEN*k+XLEN-1:XLEN*k].
REQ-009 rd, reserve, reserve_tag  input  5, 1, TAGW  reserve destination register rd with tag.
REQ-010 wreg0, wdata0, wen0, wtag0  input  5, XLEN, 1, TAGW  write port 0.
REQ-011 wreg1, wdata1, wen1, wtag1  input  5, XLEN, 1, TAGW  write port 1.
REQ-012 flush  input  1  cancel all outstanding reservations.
REQ-013 busy_count  output  6  registered count of pending registers.

Function
REQ-014 The block SHALL hold 31 XLEN-bit registers x1..x31, each with a pending bit and a TAGW-bit tag; x0 SHALL read 0 with valid 1, and all writes/reserves to x0 SHALL be ignored.
REQ-015 A write on port p SHALL be accepted iff wen_p=1, wreg_p!=0, and (pending[wreg_p]=0 or wtag_p==tag[wreg_p]); non-accepted (stale) writes SHALL change nothing.
REQ-016 An accepted write SHALL load wdata_p into the register and clear its pending bit at the next edge.
REQ-017 When both ports have accepted writes to the same register in one cycle, port 0 data SHALL win.
REQ-018 reserve=1 with rd!=0 and flush=0 SHALL set pending[rd]=1 and tag[rd]=reserve_tag at the next edge, overriding any same-cycle clear of rd by an accepted write (write data is still stored).
REQ-019 flush=1 SHALL clear all pending bits at the next edge; tags and data unchanged; same-cycle reserve SHALL be ignored; same-cycle writes SHALL be evaluated against pre-flush state and stored if accepted.
REQ-020 Reads SHALL be combinational, zero latency: for port k with address a!=0, if an accepted write targets a this cycle, rs_data=that write's data (port 0 priority) and rs_valid=1; otherwise rs_data=regs[a], rs_valid=~pending[a].
REQ-021 Read outputs SHALL NOT reflect a same-cycle reserve (reserve takes effect after the edge).
REQ-022 busy_count SHALL equal the number of pending bits set after each edge (0..31), registered, never wrapping.
REQ-023 Stored register data SHALL be updated only by accepted writes.

Reset
REQ-024 reset_n=0 at a rising edge SHALL set all registers to 0, all pending bits to 0, all tags to 0, busy_count to 0, overriding every other input in that cycle.
REQ-025 After reset, every read port SHALL return data 0 with valid 1 until written or reserved.
REQ-026 Reset asserted mid-operation (outstanding reservations) SHALL discard them; writes after release with any tag SHALL be accepted.

Verification
REQ-027 Reserve x5 tag 3; next cycle read x5 -> rs_valid=0, busy_count=1; write x5=0xDEADBEEF tag 3 on port 1 -> same-cycle read returns 0xDEADBEEF valid 1; next cycle valid 1, busy_count=0.
REQ-028 Reserve x7 tag 1, then reserve x7 tag 2; write x7=0x11 tag 1 -> dropped, x7 still pending; write x7=0x22 tag 2 -> x7=0x22 valid.
REQ-029 Same cycle: port 0 writes x9=0xAAAA, port 1 writes x9=0xBBBB, both accepted -> bypass and stored value 0xAAAA.
REQ-030 Reserve x3,x4,x6 on successive cycles (busy_count 3); assert flush with reserve x8 and accepted write x3=0x55 -> busy_count=0, x8 not pending, x3=0x55.
REQ-031 Write x0=0x1234, reserve x0 -> all ports reading x0 return 0 valid 1, busy_count 0; with NRD=4 drive four distinct addresses and check each lane independently.
REQ-032 Reserve x10, x11, pulse reset_n=0 one cycle -> all registers 0, valid 1, busy_count 0; then write x10 tag 5 -> accepted.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: 31-entry register file with a per-register pending/tag scoreboard,
// two tag-checked write ports and zero-latency bypassed read ports.
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int NRD  = 2,
   parameter int TAGW = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NRD*5-1:0]    rs_addr,
   output logic [NRD-1:0]      rs_valid,
   output logic [NRD*XLEN-1:0] rs_data,
   input  logic [4:0]          rd,
   input  logic                reserve,
   input  logic [TAGW-1:0]     reserve_tag,
   input  logic [4:0]          wreg0,
   input  logic [XLEN-1:0]     wdata0,
   input  logic                wen0,
   input  logic [TAGW-1:0]     wtag0,
   input  logic [4:0]          wreg1,
   input  logic [XLEN-1:0]     wdata1,
   input  logic                wen1,
   input  logic [TAGW-1:0]     wtag1,
   input  logic                flush,
   output logic [5:0]          busy_count
);
   logic [XLEN-1:0] regs_q [32];
   logic [XLEN-1:0] regs_d [32];
   logic [TAGW-1:0] tag_q [32];
   logic [TAGW-1:0] tag_d [32];
   logic [31:0]     pend_q, pend_d;
   logic [5:0]      busy_q, busy_d;
   logic            acc0, acc1;

   // A write is stale when its register is pending under a different tag.
   assign acc0 = wen0 && wreg0 != 5'd0 && (!pend_q[wreg0] || wtag0 == tag_q[wreg0]);
   assign acc1 = wen1 && wreg1 != 5'd0 && (!pend_q[wreg1] || wtag1 == tag_q[wreg1]);

   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      tag_d  = tag_q;
      if (acc1) begin
         regs_d[wreg1] = wdata1;
         pend_d[wreg1] = 1'b0;
      end
      if (acc0) begin
         regs_d[wreg0] = wdata0;
         pend_d[wreg0] = 1'b0;
      end
      if (flush)
         pend_d = '0;
      else if (reserve && rd != 5'd0) begin
         pend_d[rd] = 1'b1;
         tag_d[rd]  = reserve_tag;
      end
      busy_d = '0;
      for (int i = 1; i < 32; i++)
         busy_d += 6'(pend_d[i]);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         regs_q <= '{default: '0};
         tag_q  <= '{default: '0};
         pend_q <= '0;
         busy_q <= '0;
      end else begin
         regs_q <= regs_d;
         tag_q  <= tag_d;
         pend_q <= pend_d;
         busy_q <= busy_d;
      end
   end

   assign busy_count = busy_q;

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [4:0] a;
      logic       hit0, hit1;
      assign a    = rs_addr[5*k +: 5];
      assign hit0 = acc0 && wreg0 == a;
      assign hit1 = acc1 && wreg1 == a;
      assign rs_data[XLEN*k +: XLEN] = a == 5'd0 ? '0 : hit0 ? wdata0 : hit1 ? wdata1 : regs_q[a];
      assign rs_valid[k] = a == 5'd0 || hit0 || hit1 || !pend_q[a];
   end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized traffic, checked every cycle
// against an array-based scoreboard model of the register file.
module tb_regfile_sb;
   localparam int XLEN = 32;
   localparam int NRD  = 4;
   localparam int TAGW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset_n;
   logic [NRD*5-1:0]    rs_addr;
   logic [NRD-1:0]      rs_valid;
   logic [NRD*XLEN-1:0] rs_data;
   logic [4:0]          rd;
   logic                reserve;
   logic [TAGW-1:0]     reserve_tag;
   logic [4:0]          wreg0, wreg1;
   logic [XLEN-1:0]     wdata0, wdata1;
   logic                wen0, wen1;
   logic [TAGW-1:0]     wtag0, wtag1;
   logic                flush;
   logic [5:0]          busy_count;

   regfile_sb #(.XLEN(XLEN), .NRD(NRD), .TAGW(TAGW)) dut (
      .clk(clk), .reset_n(reset_n), .rs_addr(rs_addr), .rs_valid(rs_valid), .rs_data(rs_data),
      .rd(rd), .reserve(reserve), .reserve_tag(reserve_tag),
      .wreg0(wreg0), .wdata0(wdata0), .wen0(wen0), .wtag0(wtag0),
      .wreg1(wreg1), .wdata1(wdata1), .wen1(wen1), .wtag1(wtag1),
      .flush(flush), .busy_count(busy_count)
   );

   logic [XLEN-1:0] m_reg [32];
   bit              m_pend [32];
   logic [TAGW-1:0] m_tag [32];

   bit              chk_on = 1'b0;
   bit              pin_en [NRD];
   logic [XLEN-1:0] pin_data [NRD];
   bit              pin_valid [NRD];
   int              pin_busy = -1;
   int              total = 0;
   int              bad = 0;

   function automatic bit accepted(input bit en, input logic [4:0] r, input logic [TAGW-1:0] t);
      return en && r != 5'd0 && (!m_pend[r] || t == m_tag[r]);
   endfunction

   // {valid, data} a read of address a must return with the current inputs
   function automatic logic [XLEN:0] exp_read(input logic [4:0] a);
      if (a == 5'd0) return {1'b1, {XLEN{1'b0}}};
      if (accepted(wen0, wreg0, wtag0) && wreg0 == a) return {1'b1, wdata0};
      if (accepted(wen1, wreg1, wtag1) && wreg1 == a) return {1'b1, wdata1};
      return {~m_pend[a], m_reg[a]};
   endfunction

   function automatic int m_busy();
      int n = 0;
      for (int i = 1; i < 32; i++) n += int'(m_pend[i]);
      return n;
   endfunction

   task automatic model_step();
      bit a0, a1;
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0; m_pend[i] = 1'b0; m_tag[i] = '0;
         end
      end else begin
         a0 = accepted(wen0, wreg0, wtag0);
         a1 = accepted(wen1, wreg1, wtag1);
         if (a1) begin m_reg[wreg1] = wdata1; m_pend[wreg1] = 1'b0; end
         if (a0) begin m_reg[wreg0] = wdata0; m_pend[wreg0] = 1'b0; end
         if (flush) for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
         else if (reserve && rd != 5'd0) begin m_pend[rd] = 1'b1; m_tag[rd] = reserve_tag; end
      end
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < NRD; k++) begin
            logic [XLEN:0] e;
            e = exp_read(rs_addr[5*k +: 5]);
            chk($sformatf("lane%0d_data", k), 64'(rs_data[XLEN*k +: XLEN]), 64'(e[XLEN-1:0]));
            chk($sformatf("lane%0d_valid", k), 64'(rs_valid[k]), 64'(e[XLEN]));
            if (pin_en[k]) begin
               chk($sformatf("pin%0d_model_data", k), 64'(e[XLEN-1:0]), 64'(pin_data[k]));
               chk($sformatf("pin%0d_model_valid", k), 64'(e[XLEN]), 64'(pin_valid[k]));
               chk($sformatf("pin%0d_dut_data", k), 64'(rs_data[XLEN*k +: XLEN]), 64'(pin_data[k]));
               chk($sformatf("pin%0d_dut_valid", k), 64'(rs_valid[k]), 64'(pin_valid[k]));
            end
         end
         chk("busy_count", 64'(busy_count), 64'(m_busy()));
         if (pin_busy >= 0) chk("pin_busy", 64'(busy_count), 64'(pin_busy));
      end
   end

   task automatic idle();
      reset_n = 1'b1; rs_addr = '0; rd = '0; reserve = 1'b0; reserve_tag = '0;
      wreg0 = '0; wdata0 = '0; wen0 = 1'b0; wtag0 = '0;
      wreg1 = '0; wdata1 = '0; wen1 = 1'b0; wtag1 = '0; flush = 1'b0;
   endtask

   task automatic pin(input int k, input logic [4:0] a, input logic [XLEN-1:0] d, input bit v);
      rs_addr[5*k +: 5] = a;
      pin_en[k] = 1'b1; pin_data[k] = d; pin_valid[k] = v;
   endtask

   task automatic tick();
      @(negedge clk);
      #1 model_step();
      for (int k = 0; k < NRD; k++) pin_en[k] = 1'b0;
      pin_busy = -1;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int p, input logic [4:0] r, input logic [XLEN-1:0] d, input logic [TAGW-1:0] t);
      if (p == 0) begin wreg0 = r; wdata0 = d; wen0 = 1'b1; wtag0 = t; end
      else begin wreg1 = r; wdata1 = d; wen1 = 1'b1; wtag1 = t; end
   endtask

   task automatic rsv(input logic [4:0] r, input logic [TAGW-1:0] t);
      rd = r; reserve = 1'b1; reserve_tag = t;
   endtask

   initial begin
      for (int k = 0; k < NRD; k++) pin_en[k] = 1'b0;
      idle();
      reset_n = 1'b0;
      tick();
      chk_on = 1'b1;
      // reset state
      idle(); pin(0, 5, 0, 1); pin(1, 31, 0, 1); pin_busy = 0; tick();
      // reserve x5 tag 3; read not affected same cycle
      idle(); rsv(5, 3); pin(0, 5, 0, 1); pin_busy = 0; tick();
      idle(); pin(0, 5, 0, 0); pin_busy = 1; tick();
      idle(); wr(1, 5, 32'hDEADBEEF, 3); pin(0, 5, 32'hDEADBEEF, 1); pin_busy = 1; tick();
      idle(); pin(0, 5, 32'hDEADBEEF, 1); pin_busy = 0; tick();
      // re-reserve with a new tag: the old-tag write is stale
      idle(); rsv(7, 1); tick();
      idle(); rsv(7, 2); tick();
      idle(); wr(0, 7, 32'h11, 1); pin(0, 7, 0, 0); pin_busy = 1; tick();
      idle(); pin(0, 7, 0, 0); pin_busy = 1; tick();
      idle(); wr(0, 7, 32'h22, 2); pin(0, 7, 32'h22, 1); pin_busy = 1; tick();
      idle(); pin(0, 7, 32'h22, 1); pin_busy = 0; tick();
      // dual write to one register: port 0 wins
      idle(); wr(0, 9, 32'hAAAA, 0); wr(1, 9, 32'hBBBB, 0); pin(0, 9, 32'hAAAA, 1); tick();
      idle(); pin(0, 9, 32'hAAAA, 1); tick();
      // flush with same-cycle reserve and accepted write
      idle(); rsv(3, 2); tick();
      idle(); rsv(4, 2); tick();
      idle(); rsv(6, 2); tick();
      idle(); flush = 1'b1; rsv(8, 1); wr(0, 3, 32'h55, 2); pin(0, 3, 32'h55, 1); pin(1, 8, 0, 1);
      pin_busy = 3; tick();
      idle(); pin(0, 3, 32'h55, 1); pin(1, 8, 0, 1); pin(2, 4, 0, 1); pin_busy = 0; tick();
      // x0 is hardwired
      idle(); wr(0, 0, 32'h1234, 0); rsv(0, 1);
      for (int k = 0; k < NRD; k++) pin(k, 0, 0, 1);
      pin_busy = 0; tick();
      idle(); pin(0, 0, 0, 1); pin(1, 3, 32'h55, 1); pin(2, 9, 32'hAAAA, 1); pin(3, 5, 32'hDEADBEEF, 1);
      pin_busy = 0; tick();
      // reset discards reservations
      idle(); rsv(10, 4); tick();
      idle(); rsv(11, 6); tick();
      idle(); reset_n = 1'b0; pin_busy = 2; tick();
      idle(); pin(0, 10, 0, 1); pin(1, 11, 0, 1); pin(2, 9, 0, 1); pin(3, 5, 0, 1); pin_busy = 0; tick();
      idle(); wr(0, 10, 32'h77, 5); pin(0, 10, 32'h77, 1); tick();
      idle(); pin(0, 10, 32'h77, 1); tick();
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         idle();
         reset_n = $urandom_range(99) != 0;
         rs_addr = (NRD*5)'({$urandom, $urandom});
         if ($urandom_range(2) == 0) rsv(5'($urandom), TAGW'($urandom));
         wreg0 = 5'($urandom);
         wreg1 = $urandom_range(3) == 0 ? wreg0 : 5'($urandom);
         wen0 = $urandom_range(1) == 1;
         wen1 = $urandom_range(1) == 1;
         wdata0 = $urandom;
         wdata1 = $urandom;
         wtag0 = $urandom_range(3) != 0 ? m_tag[wreg0] : TAGW'($urandom);
         wtag1 = $urandom_range(3) != 0 ? m_tag[wreg1] : TAGW'($urandom);
         flush = $urandom_range(19) == 0;
         if ($urandom_range(1) == 0) rs_addr[4:0] = wreg0;
         tick();
      end
      idle();
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
